ram_pack_writer: RTL and testbench

RAM_PACK_WRITER -- requirements
Module: ram_pack_writer

---
 rtl/ram_pkg.sv | 10 +
 rtl/ram_pack_writer.sv | 98 +++++++++
 tb/tb_ram_pack_writer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the half-word packing writer and its matching reader-side control.
package ram_pkg;

  // Whether the writer currently holds an upper half waiting for its partner.
  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

endpackage

// File: rtl/ram_pack_writer.sv
// Packs pairs of half-word items into full RAM words and drives a dual-port RAM write port.
// First item of a pair lands in the upper half; flush pads a lone upper half with zeros.
module ram_pack_writer
  import ram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH/2-1:0] in_data,
  input  logic               flush,
  input  logic               clear,
  output logic               wr_en,
  output logic [DEPTH-1:0]   writeAddr,
  output logic [WIDTH-1:0]   din,
  output logic [DEPTH:0]     word_count,
  output logic               full,
  output logic [DEPTH:0]     half_ptr
);

  localparam int HW = WIDTH / 2;
  localparam logic [DEPTH:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};

  pack_state_t     state;
  logic [HW-1:0]   hold;
  logic [DEPTH-1:0] pointer;
  logic            accept;
  logic            do_write;
  logic [WIDTH-1:0] word;

  assign in_ready = !full && !clear;
  assign accept   = in_valid && in_ready;
  assign half_ptr = {pointer, state == HALF};

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    do_write = 1'b0;
    word     = {hold, in_data};
    case (state)
      EMPTY: begin
        // A flushed lone item is written straight away as an upper half.
        if (accept && flush) begin
          do_write = 1'b1;
          word     = {in_data, {HW{1'b0}}};
        end
      end
      HALF: begin
        if (accept) begin
          do_write = 1'b1;
          word     = {hold, in_data};
        end else if (flush) begin
          do_write = 1'b1;
          word     = {hold, {HW{1'b0}}};
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      hold       <= '0;
      pointer    <= '0;
      word_count <= '0;
      full       <= 1'b0;
      wr_en      <= 1'b0;
      writeAddr  <= '0;
      din        <= '0;
    end else if (clear) begin
      // din and writeAddr keep their last value; only the strobe drops.
      state      <= EMPTY;
      hold       <= '0;
      pointer    <= '0;
      word_count <= '0;
      full       <= 1'b0;
      wr_en      <= 1'b0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        din        <= word;
        writeAddr  <= pointer;
        pointer    <= pointer + 1'b1;
        word_count <= word_count + 1'b1;
        full       <= (word_count + 1'b1) == CAPACITY;
        state      <= EMPTY;
      end else if (state == EMPTY && accept) begin
        hold  <= in_data;
        state <= HALF;
      end
    end
  end

endmodule

// File: tb/tb_ram_pack_writer.sv
// Randomized self-checking bench for ram_pack_writer built around a half-word slot model.
module tb_ram_pack_writer;

  localparam int DEPTH  = 4;
  localparam int WIDTH  = 8;
  localparam int NWORDS = 16;
  localparam int NHALF  = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic             flush;
  logic             clear;
  logic             wr_en;
  logic [DEPTH-1:0] writeAddr;
  logic [WIDTH-1:0] din;
  logic [DEPTH:0]   word_count;
  logic             full;
  logic [DEPTH:0]   half_ptr;

  ram_pack_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .clear      (clear),
    .wr_en      (wr_en),
    .writeAddr  (writeAddr),
    .din        (din),
    .word_count (word_count),
    .full       (full),
    .half_ptr   (half_ptr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: a linear sequence of half-word slots; hp is the next free slot.
  logic [3:0] halves[NHALF];
  int         hp;
  logic       exp_wr;
  logic [3:0] exp_addr;
  logic [7:0] exp_din;
  int         wr_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    int old_hp;
    old_hp = hp;
    exp_wr = 1'b0;
    if (clear) begin
      hp = 0;
    end else begin
      if (in_valid && hp != NHALF) begin
        halves[hp] = in_data;
        hp++;
      end
      if (flush && (hp % 2) == 1) begin
        halves[hp] = 4'h0;
        hp++;
      end
      if (hp / 2 != old_hp / 2) begin
        exp_wr   = 1'b1;
        exp_addr = 4'((hp / 2 - 1) % NWORDS);
        exp_din  = {halves[hp-2], halves[hp-1]};
      end
    end
  endtask

  // Drive one cycle of inputs; return just after the edge has been applied.
  task automatic step(input logic v, input logic [3:0] d, input logic f, input logic c);
    in_valid = v;
    in_data  = d;
    flush    = f;
    clear    = c;
    @(posedge clk);
    model_edge();
    #2;
    if (wr_en) wr_seen++;
  endtask

  task automatic pulse_reset();
    reset_n  = 1'b0;
    hp       = 0;
    exp_wr   = 1'b0;
    exp_addr = '0;
    exp_din  = '0;
    #1;
    check("rst wr_en", wr_en, 0);
    check("rst writeAddr", writeAddr, 0);
    check("rst din", din, 0);
    check("rst word_count", word_count, 0);
    check("rst full", full, 0);
    check("rst half_ptr", half_ptr, 0);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    check("cmp wr_en", wr_en, exp_wr);
    check("cmp writeAddr", writeAddr, exp_addr);
    check("cmp din", din, exp_din);
    check("cmp word_count", word_count, hp / 2);
    check("cmp full", full, hp == NHALF);
    check("cmp in_ready", in_ready, (hp != NHALF) && !clear);
    check("cmp half_ptr", half_ptr, hp % NHALF);
  end

  initial begin
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    clear    = 1'b0;
    wr_seen  = 0;
    pulse_reset();

    // Simple pair from reset.
    step(1'b1, 4'hA, 1'b0, 1'b0);
    check("pair half_ptr mid", half_ptr, 1);
    step(1'b1, 4'hB, 1'b0, 1'b0);
    check("pair wr_en", wr_en, 1);
    check("pair addr", writeAddr, 0);
    check("pair din", din, 8'hAB);
    check("pair count", word_count, 1);
    check("pair half_ptr", half_ptr, 2);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("pair pulse ends", wr_en, 0);
    check("pair din held", din, 8'hAB);

    // Stream until full, then keep pushing.
    pulse_reset();
    wr_seen = 0;
    for (int i = 0; i < 32; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
    check("fill writes", wr_seen, 16);
    check("fill full", full, 1);
    check("fill in_ready", in_ready, 0);
    check("fill count", word_count, 16);
    check("fill last addr", writeAddr, 15);
    check("fill last din", din, 8'hEF);
    check("fill half_ptr wrap", half_ptr, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h5, 1'b1, 1'b0);
    check("full no more writes", wr_seen, 16);

    // Flush after an idle cycle, then a normal pair.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0);
    check("flush wr_en", wr_en, 1);
    check("flush din", din, 8'h50);
    check("flush addr", writeAddr, 0);
    step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 4'h2, 1'b0, 1'b0);
    check("after flush din", din, 8'h12);
    check("after flush addr", writeAddr, 1);

    // Flush together with a beat while empty.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'hC, 1'b1, 1'b0);
    check("flush+beat wr_en", wr_en, 1);
    check("flush+beat din", din, 8'hC0);
    check("flush+beat half_ptr", half_ptr, 2);

    // Clear discards a pending half.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'h7, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    check("clear no write", wr_en, 0);
    check("clear count", word_count, 0);
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    check("post clear din", din, 8'h34);
    check("post clear addr", writeAddr, 0);
    check("post clear count", word_count, 1);

    // Asynchronous reset in the middle of a pair.
    step(1'b1, 4'h9, 1'b0, 1'b0);
    check("mid pair half_ptr", half_ptr, 3);
    in_valid = 1'b0;
    pulse_reset();
    step(1'b1, 4'h6, 1'b0, 1'b0);
    step(1'b1, 4'h8, 1'b0, 1'b0);
    check("post reset din", din, 8'h68);
    check("post reset addr", writeAddr, 0);

    // Randomized traffic against the slot model.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 59) == 0);
    end
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
